snax_data_reshuffler_ctrl: RTL

//  Job controller between the CSR manager, the streamer and the data reshuffler.
//  - Latches one job (transpose enable, beat count N) from CSRs and hands the mode word to the reshuffler over a valid/ready config port.
//  - Opens the 512b input/output stream gates for exactly N beats each, then reports done/busy via read-only CSRs.

---
 rtl/snax_data_reshuffler_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/snax_data_reshuffler_ctrl.sv
// Job controller: latches one reshuffle job from CSRs, configures the reshuffler,
// gates N beats through each stream and reports busy/done. Optional: SNAX_RESHUF_CTRL_PERF_EN.
module snax_data_reshuffler_ctrl #(
    parameter int RegRWCount   = 2,
    parameter int RegROCount   = 2,
    parameter int RegDataWidth = 32,
    parameter int DataWidth    = 512,
    parameter int CntWidth     = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
    input  logic                               csr_reg_set_valid_i,
    output logic                               csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
    input  logic [DataWidth-1:0]               stream2acc_0_data_i,
    input  logic                               stream2acc_0_valid_i,
    output logic                               stream2acc_0_ready_o,
    output logic [DataWidth-1:0]               acc2stream_0_data_o,
    output logic                               acc2stream_0_valid_o,
    input  logic                               acc2stream_0_ready_i,
    output logic [DataWidth-1:0]               reshuf_a_data_o,
    output logic                               reshuf_a_valid_o,
    input  logic                               reshuf_a_ready_i,
    input  logic [DataWidth-1:0]               reshuf_z_data_i,
    input  logic                               reshuf_z_valid_i,
    output logic                               reshuf_z_ready_o,
    output logic [RegDataWidth-1:0]            reshuf_cfg_transpose_o,
    output logic                               reshuf_cfg_valid_o,
    input  logic                               reshuf_cfg_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [RegDataWidth-1:0] r_cfg_word;
    logic [RegDataWidth-1:0] r_beats;
    logic [CntWidth-1:0]     r_in_cnt;
    logic [CntWidth-1:0]     r_out_cnt;
    logic                    r_done;

    logic [CntWidth-1:0]     w_n;
    logic                    w_run;
    logic                    w_in_open;
    logic                    w_out_open;
    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_last_out;
    logic                    w_accept;
    logic                    w_busy;
    logic [RegDataWidth-1:0] w_status;
    logic [RegDataWidth-1:0] w_perf_word;

    assign w_n        = CntWidth'(r_beats);
    assign w_run      = (r_state == S_RUN);
    assign w_in_open  = w_run && (r_in_cnt != w_n);
    assign w_out_open = w_run && (r_out_cnt != w_n);
    assign w_busy     = (r_state != S_IDLE);
    assign w_accept   = (r_state == S_IDLE) && csr_reg_set_valid_i;

    // Stream gates: data is a pure wire, only the handshake is qualified.
    assign reshuf_a_data_o      = stream2acc_0_data_i;
    assign acc2stream_0_data_o  = reshuf_z_data_i;
    assign reshuf_a_valid_o     = stream2acc_0_valid_i & w_in_open;
    assign stream2acc_0_ready_o = reshuf_a_ready_i & w_in_open;
    assign acc2stream_0_valid_o = reshuf_z_valid_i & w_out_open;
    assign reshuf_z_ready_o     = acc2stream_0_ready_i & w_out_open;

    assign w_in_hs    = stream2acc_0_valid_i & reshuf_a_ready_i & w_in_open;
    assign w_out_hs   = reshuf_z_valid_i & acc2stream_0_ready_i & w_out_open;
    assign w_last_out = w_out_hs && (r_out_cnt == (w_n - CntWidth'(1)));

    assign reshuf_cfg_transpose_o = r_cfg_word;

    always_comb begin
        w_state_nxt         = r_state;
        csr_reg_set_ready_o = 1'b0;
        reshuf_cfg_valid_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                csr_reg_set_ready_o = 1'b1;
                if (csr_reg_set_valid_i) w_state_nxt = S_CFG;
            end
            S_CFG: begin
                reshuf_cfg_valid_o = 1'b1;
                if (reshuf_cfg_ready_i) w_state_nxt = (w_n == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_last_out) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cfg_word <= '0;
            r_beats    <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cfg_word <= csr_reg_set_i[RegDataWidth-1:0];
                r_beats    <= csr_reg_set_i[2*RegDataWidth-1:RegDataWidth];
                r_in_cnt   <= '0;
                r_out_cnt  <= '0;
                r_done     <= 1'b0;
            end else begin
                if (w_in_hs)  r_in_cnt  <= r_in_cnt + CntWidth'(1);
                if (w_out_hs) r_out_cnt <= r_out_cnt + CntWidth'(1);
                if (r_state == S_DONE) r_done <= 1'b1;
            end
        end
    end

`ifdef SNAX_RESHUF_CTRL_PERF_EN
    logic [CntWidth-1:0] r_perf;

    // Saturating busy-cycle counter; frozen once the job returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (w_busy && (r_perf != '1)) begin
            r_perf <= r_perf + CntWidth'(1);
        end
    end

    assign w_perf_word = RegDataWidth'(r_perf);
`else
    assign w_perf_word = '0;
`endif

    always_comb begin
        w_status    = '0;
        w_status[0] = w_busy;
        w_status[1] = r_done;
    end

    assign csr_reg_ro_set_o = {w_perf_word, w_status};

endmodule
